hazard_sequencer: RTL and testbench

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/hazard_sequencer_if.sv | 46 ++++
 rtl/hazard_sequencer.sv | 137 +++++++++++++
 tb/tb_hazard_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// Hazard sequencer bus.
// Groups the pipeline status the sequencer observes with the pipeline-register
// controls it drives. The pipeline (or a testbench) uses the master modport and
// drives the status side. The sequencer uses the slave modport.
//   Status (master -> slave):
//     ex_memread, ex_rt, id_rs, id_rt, id_op, ex_branch_taken, ex_mdu_start,
//     mem_access, mem_ready
//   Control (slave -> master):
//     pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush,
//     pipe_freeze, mdu_done, state, stall_cycles
interface hazard_sequencer_if;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [5:0]  id_op;
  logic        ex_branch_taken;
  logic        ex_mdu_start;
  logic        mem_access;
  logic        mem_ready;

  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_we;
  logic        idex_flush;
  logic        exmem_flush;
  logic        pipe_freeze;
  logic        mdu_done;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  modport master (
    output ex_memread, ex_rt, id_rs, id_rt, id_op, ex_branch_taken, ex_mdu_start,
           mem_access, mem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush,
           pipe_freeze, mdu_done, state, stall_cycles
  );

  modport slave (
    input  ex_memread, ex_rt, id_rs, id_rt, id_op, ex_branch_taken, ex_mdu_start,
           mem_access, mem_ready,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush,
           pipe_freeze, mdu_done, state, stall_cycles
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer.
// It resolves the pipeline hazards in this order, highest first: memory freeze,
// taken branch, multiply/divide hold, and load-use stall. It drives the PC and
// pipeline-register enables and flushes, and it keeps a saturating count of the
// cycles in which the PC did not advance.
// Ports:
//   clk    - single clock; all state updates on its rising edge
//   reset  - synchronous, active-high reset
//   bus    - hazard_sequencer_if.slave (pipeline status in, controls out)
// Parameter:
//   MDU_LAT - total EX-hold cycles for a multiply/divide op (2..15)
module hazard_sequencer #(
  parameter int unsigned MDU_LAT = 8
) (
  input  logic             clk,
  input  logic             reset,
  hazard_sequencer_if.slave bus
);

  localparam logic [1:0] StRun       = 2'd0;
  localparam logic [1:0] StLoadStall = 2'd1;
  localparam logic [1:0] StMduBusy   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q, stall_d;

  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush;
  logic pipe_freeze, mdu_done;
  logic freeze, load_use;

  assign freeze = bus.mem_access & ~bus.mem_ready;

  // The rt comparison does not apply to the two opcodes that write rt rather than read it.
  assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     ((bus.ex_rt == bus.id_rt) &&
                      (bus.id_op != 6'b100011) && (bus.id_op != 6'b001110)));

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_freeze = 1'b0;
    mdu_done    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (reset) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_we = 1'b0;
      state_d = StRun;
      cnt_d   = '0;
    end else if (freeze) begin
      // State and counter hold, so an interrupted MDU op resumes where it stopped.
      pipe_freeze = 1'b1;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (bus.ex_mdu_start) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_flush = 1'b1;
            // This cycle is the first hold cycle. MDU_BUSY covers the rest.
            cnt_d       = 4'(MDU_LAT - 2);
            state_d     = StMduBusy;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            state_d    = StLoadStall;
          end
        end
        StLoadStall: begin
          if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end
          state_d = StRun;
        end
        StMduBusy: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_we     = 1'b0;
          exmem_flush = 1'b1;
          if (cnt_q == 4'd0) begin
            mdu_done = 1'b1;
            state_d  = StRun;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_we && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.ifid_we      = ifid_we;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_we      = idex_we;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.pipe_freeze  = pipe_freeze;
  assign bus.mdu_done     = mdu_done;
  assign bus.state        = state_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  logic clk;
  logic reset;

  hazard_sequencer_if bus ();

  hazard_sequencer #(
    .MDU_LAT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order:
  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, pipe_freeze, mdu_done}
  localparam logic [7:0] C_RST   = 8'b0000_0000;
  localparam logic [7:0] C_DEF   = 8'b1101_0000;
  localparam logic [7:0] C_LU    = 8'b0001_1000;
  localparam logic [7:0] C_BR    = 8'b1111_1000;
  localparam logic [7:0] C_HOLD  = 8'b0000_0100;
  localparam logic [7:0] C_DONE  = 8'b0000_0101;
  localparam logic [7:0] C_FRZ   = 8'b0000_0010;

  typedef struct {
    string       name;
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic set_in(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] idrt, input logic [5:0] op, input logic br,
                        input logic md, input logic ma, input logic mrdy);
    bus.ex_memread      = mr;
    bus.ex_rt           = rt;
    bus.id_rs           = rs;
    bus.id_rt           = idrt;
    bus.id_op           = op;
    bus.ex_branch_taken = br;
    bus.ex_mdu_start    = md;
    bus.mem_access      = ma;
    bus.mem_ready       = mrdy;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected response for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input logic [7:0] c, input logic [1:0] s,
                     input logic [15:0] n);
    exp_t e;
    e.name = nm;
    e.ctrl = c;
    e.st   = s;
    e.cnt  = n;
    q.push_back(e);
    tick();
  endtask

  // Monitor: the outputs are combinational, so one sample per cycle on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = q.pop_front();
      act = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we, bus.idex_flush,
             bus.exmem_flush, bus.pipe_freeze, bus.mdu_done};
      total++;
      if ((act !== e.ctrl) || (bus.state !== e.st) || (bus.stall_cycles !== e.cnt)) begin
        bad++;
        $display("FAIL %s: got ctrl=%b state=%0d stall=%0d, want ctrl=%b state=%0d stall=%0d",
                 e.name, act, bus.state, bus.stall_cycles, e.ctrl, e.st, e.cnt);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    tick();
    cyc("reset", C_RST, 2'd0, 16'd0);
    reset = 1'b0;
    cyc("idle", C_DEF, 2'd0, 16'd0);

    // Load-use on rs: one bubble, then back to RUN
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("lu_rs", C_LU, 2'd0, 16'd0);
    cyc("lu_stall_state", C_DEF, 2'd1, 16'd1);
    idle();
    cyc("lu_after", C_DEF, 2'd0, 16'd1);

    // Cases that must not stall
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("no_stall_r0", C_DEF, 2'd0, 16'd1);
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 6'b100011, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("no_stall_op23", C_DEF, 2'd0, 16'd1);
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 6'b001110, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("no_stall_op0e", C_DEF, 2'd0, 16'd1);
    set_in(1'b0, 5'd7, 5'd7, 5'd7, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("no_stall_nomr", C_DEF, 2'd0, 16'd1);

    // Load-use on rt
    set_in(1'b1, 5'd7, 5'd3, 5'd7, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("lu_rt", C_LU, 2'd0, 16'd1);
    idle();
    cyc("lu_rt_stall", C_DEF, 2'd1, 16'd2);
    cyc("lu_rt_after", C_DEF, 2'd0, 16'd2);

    // Branch and load-use in the same cycle: the branch wins
    set_in(1'b1, 5'd5, 5'd5, 5'd0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("br_lu", C_BR, 2'd0, 16'd2);
    idle();
    cyc("br_after", C_DEF, 2'd0, 16'd2);

    // MDU op, 8 hold cycles, done on the last one
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("mdu_start", C_HOLD, 2'd0, 16'd2);
    idle();
    for (int i = 6; i >= 1; i--) cyc("mdu_hold", C_HOLD, 2'd2, 16'(9 - i));
    cyc("mdu_done", C_DONE, 2'd2, 16'd9);
    cyc("mdu_after", C_DEF, 2'd0, 16'd10);

    // MDU op with a 3-cycle freeze in the middle and a branch ignored while busy
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("mdu2_start", C_HOLD, 2'd0, 16'd10);
    idle();
    cyc("mdu2_c6", C_HOLD, 2'd2, 16'd11);
    cyc("mdu2_c5", C_HOLD, 2'd2, 16'd12);
    cyc("mdu2_c4", C_HOLD, 2'd2, 16'd13);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("frz1", C_FRZ, 2'd2, 16'd14);
    cyc("frz2", C_FRZ, 2'd2, 16'd15);
    cyc("frz3", C_FRZ, 2'd2, 16'd16);
    idle();
    cyc("mdu2_c3", C_HOLD, 2'd2, 16'd17);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("mdu2_br_ign", C_HOLD, 2'd2, 16'd18);
    idle();
    cyc("mdu2_c1", C_HOLD, 2'd2, 16'd19);
    cyc("mdu2_done", C_DONE, 2'd2, 16'd20);
    cyc("mdu2_after", C_DEF, 2'd0, 16'd21);

    // A branch during the load stall flushes and returns to RUN
    set_in(1'b1, 5'd9, 5'd9, 5'd0, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc("lu3", C_LU, 2'd0, 16'd21);
    set_in(1'b1, 5'd9, 5'd9, 5'd0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("ls_branch", C_BR, 2'd1, 16'd22);
    idle();
    cyc("ls_br_after", C_DEF, 2'd0, 16'd22);

    // Reset during the MDU hold at counter 3
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("mdu3_start", C_HOLD, 2'd0, 16'd22);
    idle();
    cyc("mdu3_c6", C_HOLD, 2'd2, 16'd23);
    cyc("mdu3_c5", C_HOLD, 2'd2, 16'd24);
    cyc("mdu3_c4", C_HOLD, 2'd2, 16'd25);
    reset = 1'b1;
    cyc("mdu3_reset", C_RST, 2'd2, 16'd26);
    reset = 1'b0;
    cyc("post_reset", C_DEF, 2'd0, 16'd0);

    // Saturation: 65540 frozen cycles
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) tick();
    idle();
    cyc("sat", C_DEF, 2'd0, 16'hFFFF);
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("sat_frz", C_FRZ, 2'd0, 16'hFFFF);
    idle();
    cyc("sat_nowrap", C_DEF, 2'd0, 16'hFFFF);

    tick();
    tick();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
